wb_mem_req_arbiter: RTL and testbench

- Arbitrates the five ao486 memory request channels (writeburst, writeline, readburst, readline, readcode) onto the single command engine of the Wishbone memory bridge.
- Exactly one transaction is in flight at a time. The block selects a channel, starts the engine, waits for its completion, then returns a one-cycle done pulse to the winning requester.
- Address and data muxing are handled downstream, keyed by eng_sel. This block owns sequencing and fairness only.

---
 rtl/wb_mem_req_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_mem_req_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_req_arbiter.sv
// Serialises the five ao486 memory request channels onto the single Wishbone command engine.
// Optional watchdog on the WAIT state is enabled by defining WB_MEM_ARB_TIMEOUT_EN.
module wb_mem_req_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       writeburst_do,
    output logic       writeburst_done,
    input  logic       writeline_do,
    output logic       writeline_done,
    input  logic       readburst_do,
    output logic       readburst_done,
    input  logic       readline_do,
    output logic       readline_done,
    input  logic       readcode_do,
    output logic       readcode_done,
    output logic       eng_start,
    output logic [2:0] eng_sel,
    input  logic       eng_done,
    output logic       arb_busy,
    output logic       timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} state_t;

    localparam logic [2:0] SEL_NONE  = 3'd7;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

    state_t     state, state_nx;
    logic [2:0] sel_nx, win;
    logic       start_nx, busy_nx, tmo_fire, eng_fin;
    logic [4:0] done_q, done_nx;
    logic [3:0] starve_cnt, starve_nx;

    // The engine cannot finish in its own start cycle, so eng_done is masked there.
    assign eng_fin = eng_done && !eng_start;

    always_comb begin
        win = SEL_NONE;
        if (readcode_do && starve_cnt >= STARVE_LIM) win = 3'd4;
        else if (writeburst_do)                      win = 3'd0;
        else if (writeline_do)                       win = 3'd1;
        else if (readburst_do)                       win = 3'd2;
        else if (readline_do)                        win = 3'd3;
        else if (readcode_do)                        win = 3'd4;
    end

`ifdef WB_MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo_err_q;

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            tmo_cnt   <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 1'b1 : '0;
            if (tmo_fire) tmo_err_q <= 1'b1;
        end
    end

    assign tmo_fire    = (state == S_WAIT) && !eng_fin && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign timeout_err = tmo_err_q;
`else
    assign tmo_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        sel_nx    = eng_sel;
        start_nx  = 1'b0;
        done_nx   = '0;
        starve_nx = starve_cnt;
        case (state)
            S_IDLE: begin
                if (!readcode_do) starve_nx = '0;
                if (win != SEL_NONE) begin
                    state_nx = S_WAIT;
                    sel_nx   = win;
                    start_nx = 1'b1;
                    if (win == 3'd4)                           starve_nx = '0;
                    else if (readcode_do && starve_cnt != 4'hf) starve_nx = starve_cnt + 4'd1;
                end
            end
            S_WAIT: begin
                if (eng_fin || tmo_fire) begin
                    state_nx = S_DONE;
                    done_nx  = 5'(1) << eng_sel;
                end
            end
            S_DONE: begin
                state_nx = S_HOLD;
                sel_nx   = SEL_NONE;
            end
            default: state_nx = S_IDLE;
        endcase
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state      <= S_IDLE;
            eng_sel    <= SEL_NONE;
            eng_start  <= 1'b0;
            done_q     <= '0;
            arb_busy   <= 1'b0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            eng_sel    <= sel_nx;
            eng_start  <= start_nx;
            done_q     <= done_nx;
            arb_busy   <= busy_nx;
            starve_cnt <= starve_nx;
        end
    end

    assign writeburst_done = done_q[0];
    assign writeline_done  = done_q[1];
    assign readburst_done  = done_q[2];
    assign readline_done   = done_q[3];
    assign readcode_done   = done_q[4];
endmodule

// File: tb/tb_wb_mem_req_arbiter.sv
// Directed bench for wb_mem_req_arbiter: per-cycle vector table plus hand sequences
// for starvation, asynchronous reset and the optional watchdog.
module tb_wb_mem_req_arbiter;
    logic       wb_clk = 1'b0;
    logic       wb_rst = 1'b0;
    logic [4:0] req    = '0;
    logic       eng_done = 1'b0;
    logic       writeburst_done, writeline_done, readburst_done, readline_done, readcode_done;
    logic       eng_start, arb_busy, timeout_err;
    logic [2:0] eng_sel;
    logic [4:0] done_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 wb_clk = ~wb_clk;

    wb_mem_req_arbiter #(.STARVE_LIMIT(2), .TIMEOUT_CYCLES(16)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .writeburst_do(req[0]), .writeburst_done(writeburst_done),
        .writeline_do(req[1]),  .writeline_done(writeline_done),
        .readburst_do(req[2]),  .readburst_done(readburst_done),
        .readline_do(req[3]),   .readline_done(readline_done),
        .readcode_do(req[4]),   .readcode_done(readcode_done),
        .eng_start(eng_start), .eng_sel(eng_sel), .eng_done(eng_done),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    assign done_v = {readcode_done, readline_done, readburst_done, writeline_done, writeburst_done};

    typedef struct {
        logic [4:0] req;
        logic       ed;
        logic       start;
        logic [2:0] sel;
        logic [4:0] done;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] r, input logic e, input logic s,
                       input logic [2:0] sl, input logic [4:0] d, input logic b);
        vec_t v;
        v.req = r; v.ed = e; v.start = s; v.sel = sl; v.done = d; v.busy = b;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic s, input logic [2:0] sl,
                            input logic [4:0] d, input logic b);
        chk({tag, ".start"}, int'(eng_start), int'(s));
        chk({tag, ".sel"},   int'(eng_sel),   int'(sl));
        chk({tag, ".done"},  int'(done_v),    int'(d));
        chk({tag, ".busy"},  int'(arb_busy),  int'(b));
    endtask

    // Inputs change at negedge, the DUT samples them at posedge, outputs are read at the next negedge.
    task automatic step(input logic [4:0] r, input logic e);
        req = r; eng_done = e;
        @(posedge wb_clk);
        @(negedge wb_clk);
    endtask

    // Waits for a grant with requests held, completes it one cycle after start.
    task automatic grant_one(input logic [4:0] r, output logic [2:0] sel);
        int n = 0;
        while (!eng_start && n < 20) begin
            step(r, 1'b0);
            n++;
        end
        chk("grant_wait_bound", int'(n < 20), 1);
        sel = eng_sel;
        step(r, 1'b0);
        step(r, 1'b1);
        chk("grant_done_route", int'(done_v), int'(5'(1) << sel));
        step(r, 1'b0);
        step(r, 1'b0);
    endtask

    initial begin
        logic [2:0] s;

        // single writeline request, engine finishes 4 cycles after start
        add(5'b00010, 0, 1, 1, 5'b00000, 1);
        add(5'b00010, 1, 0, 1, 5'b00000, 1);   // eng_done in start cycle is masked
        add(5'b00010, 0, 0, 1, 5'b00000, 1);
        add(5'b00010, 0, 0, 1, 5'b00000, 1);
        add(5'b00010, 0, 0, 1, 5'b00000, 1);
        add(5'b00010, 1, 0, 1, 5'b00010, 1);
        add(5'b00000, 1, 0, 7, 5'b00000, 1);   // HOLDOFF ignores eng_done
        add(5'b00000, 1, 0, 7, 5'b00000, 0);
        add(5'b00000, 1, 0, 7, 5'b00000, 0);   // IDLE ignores eng_done
        // writeburst + readline + readcode together -> 0, 3, 4
        add(5'b11001, 0, 1, 0, 5'b00000, 1);
        add(5'b11001, 1, 0, 0, 5'b00000, 1);
        add(5'b11001, 1, 0, 0, 5'b00001, 1);
        add(5'b11000, 0, 0, 7, 5'b00000, 1);
        add(5'b11000, 0, 0, 7, 5'b00000, 0);
        add(5'b11000, 0, 1, 3, 5'b00000, 1);
        add(5'b11000, 0, 0, 3, 5'b00000, 1);
        add(5'b11000, 1, 0, 3, 5'b01000, 1);
        add(5'b10000, 0, 0, 7, 5'b00000, 1);
        add(5'b10000, 0, 0, 7, 5'b00000, 0);
        add(5'b10000, 0, 1, 4, 5'b00000, 1);
        add(5'b10000, 0, 0, 4, 5'b00000, 1);
        add(5'b10000, 1, 0, 4, 5'b10000, 1);
        add(5'b00000, 0, 0, 7, 5'b00000, 1);
        add(5'b00000, 0, 0, 7, 5'b00000, 0);
        // readline drops its request mid-WAIT: still completes, no re-grant
        add(5'b01000, 0, 1, 3, 5'b00000, 1);
        add(5'b00000, 0, 0, 3, 5'b00000, 1);
        add(5'b00000, 1, 0, 3, 5'b01000, 1);
        add(5'b00000, 0, 0, 7, 5'b00000, 1);
        add(5'b00000, 0, 0, 7, 5'b00000, 0);
        add(5'b00000, 0, 0, 7, 5'b00000, 0);

        @(negedge wb_clk);
        chk_outs("reset", 1'b0, 3'd7, 5'b00000, 1'b0);
        chk("reset.timeout_err", int'(timeout_err), 0);
        wb_rst = 1'b1;
        step(5'b00000, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].req, tbl[i].ed);
            chk_outs($sformatf("vec%0d", i), tbl[i].start, tbl[i].sel, tbl[i].done, tbl[i].busy);
        end

        // starvation with STARVE_LIMIT=2: writeburst wins twice, then readcode
        grant_one(5'b10011, s); chk("starve.g1", int'(s), 0);
        grant_one(5'b10011, s); chk("starve.g2", int'(s), 0);
        begin
            int n = 0;
            while (!eng_start && n < 20) begin step(5'b10011, 1'b0); n++; end
            chk("starve.g3_bound", int'(n < 20), 1);
            chk("starve.g3", int'(eng_sel), 4);
            chk("starve.cnt_clear", int'(dut.starve_cnt), 0);
            step(5'b00011, 1'b0);
            step(5'b00000, 1'b1);
            chk("starve.g3_done", int'(done_v), int'(5'b10000));
            step(5'b00000, 1'b0);
            step(5'b00000, 1'b0);
        end

        // asynchronous reset mid-WAIT with readburst granted
        step(5'b00100, 1'b0);
        chk_outs("rstw.grant", 1'b1, 3'd2, 5'b00000, 1'b1);
        step(5'b00100, 1'b0);
        #1 wb_rst = 1'b0;
        #1 chk_outs("rstw.async", 1'b0, 3'd7, 5'b00000, 1'b0);
        @(posedge wb_clk);
        @(negedge wb_clk);
        chk_outs("rstw.held", 1'b0, 3'd7, 5'b00000, 1'b0);
        wb_rst = 1'b1;
        step(5'b00100, 1'b0);
        chk_outs("rstw.regrant", 1'b1, 3'd2, 5'b00000, 1'b1);
        step(5'b00100, 1'b0);
        step(5'b00100, 1'b1);
        chk_outs("rstw.done", 1'b0, 3'd2, 5'b00100, 1'b1);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);
        chk_outs("rstw.idle", 1'b0, 3'd7, 5'b00000, 1'b0);

`ifdef WB_MEM_ARB_TIMEOUT_EN
        // engine never completes: readcode_done after 16 WAIT cycles
        step(5'b10000, 1'b0);
        chk_outs("tmo.grant", 1'b1, 3'd4, 5'b00000, 1'b1);
        chk("tmo.err_before", int'(timeout_err), 0);
        for (int k = 0; k < 15; k++) step(5'b10000, 1'b0);
        chk_outs("tmo.wait16", 1'b0, 3'd4, 5'b00000, 1'b1);
        step(5'b10000, 1'b0);
        chk_outs("tmo.fire", 1'b0, 3'd4, 5'b10000, 1'b1);
        chk("tmo.err_set", int'(timeout_err), 1);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00000, 1'b0);
        chk("tmo.err_sticky", int'(timeout_err), 1);
`else
        chk("tmo.off", int'(timeout_err), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
